// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply and restoring
// divide, one bit per cycle, with a one-cycle fast path for special operands.
module mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_V  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES_V = {XLEN{1'b1}};
    localparam logic [CW-1:0]   LAST_C = CW'(XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            mul_q, mul_d;
    logic            high_q, high_d;
    logic            rem_q, rem_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] b_q, b_d;
    logic [XLEN-1:0] hi_q, hi_d;
    logic [XLEN-1:0] lo_q, lo_d;
    logic [XLEN-1:0] result_q, result_d;

    logic            op_mul, op_mulh, op_div, op_rem, op_remu, op_divu;
    logic            op_ok, op_divide, op_signed, s1_neg, s2_neg;
    logic            div_zero, div_ovf, fast;
    logic [XLEN-1:0] abs1, abs2, fast_res;

    always_comb begin
        op_mul    = (op_i == 4'b1010);
        op_div    = (op_i == 4'b1011);
        op_rem    = (op_i == 4'b1100);
        op_mulh   = (op_i == 4'b1101);
        op_remu   = (op_i == 4'b1110);
        op_divu   = (op_i == 4'b1111);
        op_ok     = op_mul | op_mulh | op_div | op_rem | op_remu | op_divu;
        op_divide = op_div | op_rem | op_remu | op_divu;
        op_signed = op_mul | op_mulh | op_div | op_rem;
        s1_neg    = op_signed & src1_i[XLEN-1];
        s2_neg    = op_signed & src2_i[XLEN-1];
        abs1      = s1_neg ? (~src1_i + 1'b1) : src1_i;
        abs2      = s2_neg ? (~src2_i + 1'b1) : src2_i;
        div_zero  = op_divide && (src2_i == '0);
        div_ovf   = (op_div | op_rem) && (src1_i == MIN_V) && (src2_i == ONES_V);
        fast      = !op_ok || div_zero || div_ovf;
        fast_res  = '0;
        if (div_zero)
            fast_res = (op_div | op_divu) ? ONES_V : src1_i;
        else if (div_ovf)
            fast_res = op_div ? MIN_V : '0;
    end

    // One iteration of each engine; hi:lo is product, or remainder:quotient.
    logic [XLEN:0]     mul_sum, div_sh;
    logic              div_ge;
    logic [XLEN-1:0]   step_hi, step_lo, div_val;
    logic [2*XLEN-1:0] prod, prod_s;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_sh  = {hi_q, lo_q[XLEN-1]};
        div_ge  = (div_sh >= {1'b0, b_q});
        if (mul_q) begin
            step_hi = mul_sum[XLEN:1];
            step_lo = {mul_sum[0], lo_q[XLEN-1:1]};
        end else begin
            step_hi = div_ge ? (div_sh[XLEN-1:0] - b_q) : div_sh[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], div_ge};
        end
        prod    = {step_hi, step_lo};
        prod_s  = neg_q ? (~prod + 1'b1) : prod;
        div_val = rem_q ? step_hi : step_lo;
        if (neg_q)
            div_val = ~div_val + 1'b1;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mul_d    = mul_q;
        high_d   = high_q;
        rem_d    = rem_q;
        neg_d    = neg_q;
        b_d      = b_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    mul_d  = op_mul | op_mulh;
                    high_d = op_mulh;
                    rem_d  = op_rem | op_remu;
                    neg_d  = op_rem ? s1_neg : (s1_neg ^ s2_neg);
                    b_d    = (op_mul | op_mulh) ? abs1 : abs2;
                    lo_d   = (op_mul | op_mulh) ? abs2 : abs1;
                    hi_d   = '0;
                    cnt_d  = '0;
                    if (fast) begin
                        result_d = fast_res;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                hi_d  = step_hi;
                lo_d  = step_lo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_C) begin
                    result_d = mul_q ? (high_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0])
                                     : div_val;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // Flush wins everywhere and leaves the visible result untouched.
        if (flush_i) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mul_q    <= 1'b0;
            high_q   <= 1'b0;
            rem_q    <= 1'b0;
            neg_q    <= 1'b0;
            b_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mul_q    <= mul_d;
            high_q   <= high_d;
            rem_q    <= rem_d;
            neg_q    <= neg_d;
            b_q      <= b_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign result_o    = result_q;
endmodule
